// File: rtl/bsg_mem_2rw_sync_arb.sv
// bsg_mem_2rw_sync_arb
//   Arbitrates num_req_p requesters onto one dual-port synchronous RAM
//   (1-cycle read latency). Up to two requests are granted per cycle:
//   the first valid requester in round-robin order takes port A, and the
//   next valid requester that does not collide with A takes port B.
//   Read data is routed back to the originating requester one cycle later.
//
// Ports
//   clk_i, reset_n_i          clock, asynchronous active-low reset
//   req_v_i/req_w_i           per-requester valid / write
//   req_addr_i/req_data_i     packed per-requester address / write data
//   req_yumi_o                request accepted this cycle
//   a_*_o, b_*_o              RAM port A/B command (v, w, addr, data)
//   a_data_i, b_data_i        RAM port A/B read data
//   resp_v_o/resp_data_o      per-requester read response
//   conflict_cnt_o            cycles in which a colliding request was skipped
//   grant_cnt_o               total grants issued
//
// Build option
//   BSG_MEM_2RW_SYNC_ARB_STATS_EN : when defined, conflict_cnt_o (saturating)
//   and grant_cnt_o (wrapping) are live counters; otherwise both are tied 0.

module bsg_mem_2rw_sync_arb #(
    parameter int width_p   = 32,
    parameter int els_p     = 64,
    parameter int num_req_p = 4,
    localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int tag_width_lp  = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic [num_req_p-1:0]               req_v_i,
    input  logic [num_req_p-1:0]               req_w_i,
    input  logic [num_req_p*addr_width_lp-1:0] req_addr_i,
    input  logic [num_req_p*width_p-1:0]       req_data_i,
    output logic [num_req_p-1:0]               req_yumi_o,
    output logic                               a_v_o,
    output logic                               a_w_o,
    output logic [addr_width_lp-1:0]           a_addr_o,
    output logic [width_p-1:0]                 a_data_o,
    output logic                               b_v_o,
    output logic                               b_w_o,
    output logic [addr_width_lp-1:0]           b_addr_o,
    output logic [width_p-1:0]                 b_data_o,
    input  logic [width_p-1:0]                 a_data_i,
    input  logic [width_p-1:0]                 b_data_i,
    output logic [num_req_p-1:0]               resp_v_o,
    output logic [num_req_p*width_p-1:0]       resp_data_o,
    output logic [15:0]                        conflict_cnt_o,
    output logic [31:0]                        grant_cnt_o
);

    typedef logic [tag_width_lp-1:0] tag_t;
    typedef logic [tag_width_lp:0]   tag_ext_t;

    localparam tag_ext_t num_req_lp = tag_ext_t'(num_req_p);

    // (base + off) mod num_req_p, valid for base, off < num_req_p
    function automatic tag_t wrap_add(input tag_t base, input tag_ext_t off);
        tag_ext_t s;
        s = {1'b0, base} + off;
        if (s >= num_req_lp) s = s - num_req_lp;
        return s[tag_width_lp-1:0];
    endfunction

    logic [addr_width_lp-1:0] addr_arr [num_req_p];
    logic [width_p-1:0]       data_arr [num_req_p];

    always_comb begin
        for (int unsigned i = 0; i < num_req_p; i++) begin
            addr_arr[i] = req_addr_i[i*addr_width_lp +: addr_width_lp];
            data_arr[i] = req_data_i[i*width_p +: width_p];
        end
    end

    tag_t rr_q;
    logic pend_a_q, pend_b_q;
    tag_t tag_a_q, tag_b_q;

    logic a_found, b_found, skipped;
    tag_t a_idx, b_idx;
    logic a_grant, b_grant;

    // Single round-robin scan: first valid takes A; afterwards, candidates
    // colliding with A are passed over until a compatible one takes B.
    always_comb begin
        tag_t idx;
        a_found = 1'b0;
        b_found = 1'b0;
        skipped = 1'b0;
        a_idx   = '0;
        b_idx   = '0;
        idx     = '0;
        for (int unsigned k = 0; k < num_req_p; k++) begin
            idx = wrap_add(rr_q, tag_ext_t'(k));
            if (req_v_i[idx]) begin
                if (!a_found) begin
                    a_found = 1'b1;
                    a_idx   = idx;
                end else if (!b_found) begin
                    if ((addr_arr[idx] == addr_arr[a_idx]) && (req_w_i[idx] || req_w_i[a_idx])) begin
                        skipped = 1'b1;
                    end else begin
                        b_found = 1'b1;
                        b_idx   = idx;
                    end
                end
            end
        end
    end

    // Grants are suppressed while reset is held, independent of the clock.
    assign a_grant = a_found & reset_n_i;
    assign b_grant = b_found & reset_n_i;

    always_comb begin
        req_yumi_o = '0;
        if (a_grant) req_yumi_o[a_idx] = 1'b1;
        if (b_grant) req_yumi_o[b_idx] = 1'b1;
    end

    assign a_v_o    = a_grant;
    assign a_w_o    = a_grant & req_w_i[a_idx];
    assign a_addr_o = a_grant ? addr_arr[a_idx] : '0;
    assign a_data_o = a_grant ? data_arr[a_idx] : '0;
    assign b_v_o    = b_grant;
    assign b_w_o    = b_grant & req_w_i[b_idx];
    assign b_addr_o = b_grant ? addr_arr[b_idx] : '0;
    assign b_data_o = b_grant ? data_arr[b_idx] : '0;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rr_q     <= '0;
            pend_a_q <= 1'b0;
            pend_b_q <= 1'b0;
            tag_a_q  <= '0;
            tag_b_q  <= '0;
        end else begin
            if (a_grant) rr_q <= wrap_add(b_grant ? b_idx : a_idx, tag_ext_t'(1));
            pend_a_q <= a_grant & ~req_w_i[a_idx];
            pend_b_q <= b_grant & ~req_w_i[b_idx];
            tag_a_q  <= a_idx;
            tag_b_q  <= b_idx;
        end
    end

    // A and B tags are never equal, so the two writes below never overlap.
    always_comb begin
        resp_v_o    = '0;
        resp_data_o = '0;
        if (pend_a_q) begin
            resp_v_o[tag_a_q] = 1'b1;
            resp_data_o[int'(tag_a_q)*width_p +: width_p] = a_data_i;
        end
        if (pend_b_q) begin
            resp_v_o[tag_b_q] = 1'b1;
            resp_data_o[int'(tag_b_q)*width_p +: width_p] = b_data_i;
        end
    end

`ifdef BSG_MEM_2RW_SYNC_ARB_STATS_EN
    logic [15:0] conflict_cnt_q;
    logic [31:0] grant_cnt_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            conflict_cnt_q <= '0;
            grant_cnt_q    <= '0;
        end else begin
            if (skipped && (conflict_cnt_q != '1)) conflict_cnt_q <= conflict_cnt_q + 16'd1;
            grant_cnt_q <= grant_cnt_q + 32'(a_grant) + 32'(b_grant);
        end
    end

    assign conflict_cnt_o = conflict_cnt_q;
    assign grant_cnt_o    = grant_cnt_q;
`else
    logic unused_skipped;
    assign unused_skipped = skipped;
    assign conflict_cnt_o = '0;
    assign grant_cnt_o    = '0;
`endif

endmodule
